// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding and default widths for the capture sequencer.
package capture_pkg;
  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} capture_state_t;
  localparam int CAP_ADDR_W = 9;
  localparam int DEC_W = 4;
endpackage

// File: rtl/capture_ctrl_sample_tick.sv
// sample_tick: decimation counter producing one sample tick every 2^dec clocks.
module sample_tick
  import capture_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DEC_W-1:0] dec,
  output logic             tick
);
  logic [14:0] cnt_q;
  logic [14:0] mask;
  assign mask = ~(15'h7fff << dec);
  assign tick = cnt_q == mask;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else cnt_q <= tick ? '0 : cnt_q + 15'd1;
  end
endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: pre-fill / armed / post-count sequencer for a circular sample buffer,
// holding the finished capture until readout is acknowledged.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int ADDR_W = CAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_start,
  input  logic              capture_done_clr,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [DEC_W-1:0]  decimator,
  input  logic              trigger,
  output logic              armed,
  output logic              set_capture_done,
  output logic              capture_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);
  localparam int DEPTH = 2 ** ADDR_W;
  capture_state_t    state_q, state_d;
  logic [ADDR_W-1:0] tp_q, tp_d;
  logic [DEC_W-1:0]  dec_q, dec_d;
  logic [ADDR_W:0]   pre_q, pre_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic              start, tick, post_full;
  assign start = state_q == IDLE && capture_start;
  sample_tick u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .dec  (dec_q),
    .tick (tick)
  );
  assign post_full        = post_q == tp_q;
  assign we               = tick && (state_q == FILL || state_q == ARMED || (state_q == POST && !post_full));
  assign armed            = state_q == ARMED;
  assign capture_done     = state_q == DONE;
  assign set_capture_done = state_q == POST && post_full;
  assign waddr            = waddr_q;
  assign trig_addr        = trig_addr_q;
  assign start_addr       = start_addr_q;
  always_comb begin
    state_d      = state_q;
    tp_d         = tp_q;
    dec_d        = dec_q;
    waddr_d      = waddr_q + ADDR_W'(we);
    pre_d        = pre_q + (ADDR_W+1)'(state_q == FILL && we);
    post_d       = post_q + ADDR_W'(state_q == POST && we);
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    case (state_q)
      IDLE: if (capture_start) begin
        state_d = FILL;
        tp_d    = trig_pos;
        dec_d   = decimator;
        pre_d   = '0;
        post_d  = '0;
      end
      // compare the post-write count so ARMED follows the final pre-fill write directly
      FILL:  if (pre_d == (ADDR_W+1)'(DEPTH) - {1'b0, tp_q}) state_d = ARMED;
      ARMED: if (trigger) begin
        state_d     = POST;
        trig_addr_d = waddr_d;
      end
      POST: if (post_full) begin
        state_d      = DONE;
        start_addr_d = waddr_q;
      end
      DONE:    if (capture_done_clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tp_q         <= '0;
      dec_q        <= '0;
      pre_q        <= '0;
      post_q       <= '0;
      waddr_q      <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      tp_q         <= tp_d;
      dec_q        <= dec_d;
      pre_q        <= pre_d;
      post_q       <= post_d;
      waddr_q      <= waddr_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
    end
  end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: randomized capture sequences checked cycle by cycle against a phase-level model.
module tb_capture_ctrl;
  localparam int AW = 4;
  localparam int D = 16;
  localparam int M_IDLE = 0, M_FILL = 1, M_ARMED = 2, M_POST = 3, M_DONE = 4;
  logic          clk = 1'b0;
  logic          rst, capture_start, capture_done_clr, trigger;
  logic [AW-1:0] trig_pos;
  logic [3:0]    decimator;
  logic          armed, set_capture_done, capture_done, we;
  logic [AW-1:0] waddr, trig_addr, start_addr;
  int total = 0, bad = 0;
  int ph = M_IDLE, cyc = 0, tp = 0, per = 1, npre = 0, npost = 0;
  int wa = 0, ta = 0, sa = 0, acnt = 0, tdel = 0;
  bit trig_q = 1'b0;
  always #5 clk = ~clk;
  capture_ctrl #(.ADDR_W(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .capture_start    (capture_start),
    .capture_done_clr (capture_done_clr),
    .trig_pos         (trig_pos),
    .decimator        (decimator),
    .trigger          (trigger),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .capture_done     (capture_done),
    .we               (we),
    .waddr            (waddr),
    .trig_addr        (trig_addr),
    .start_addr       (start_addr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle();
    int we_e, arm_e, scd_e, done_e, w0;
    bit trig_set;
    we_e   = (ph == M_FILL || ph == M_ARMED || (ph == M_POST && npost < tp)) && (cyc % per == per - 1);
    arm_e  = ph == M_ARMED;
    scd_e  = ph == M_POST && npost == tp;
    done_e = ph == M_DONE;
    chk("we", we, we_e);
    chk("armed", armed, arm_e);
    chk("set_capture_done", set_capture_done, scd_e);
    chk("capture_done", capture_done, done_e);
    chk("waddr", waddr, wa);
    chk("trig_addr", trig_addr, ta);
    chk("start_addr", start_addr, sa);
    trig_set = arm_e && acnt == tdel;
    @(posedge clk);
    if (rst) begin
      ph = M_IDLE; wa = 0; ta = 0; sa = 0; npre = 0; npost = 0; cyc = 0; trig_q = 1'b0;
    end else begin
      w0 = wa;
      if (we_e) wa = (wa + 1) % D;
      cyc++;
      case (ph)
        M_IDLE: if (capture_start) begin
          ph = M_FILL; tp = trig_pos; per = 1 << decimator; cyc = 0; npre = 0; npost = 0; acnt = 0;
        end
        M_FILL: begin
          npre += we_e;
          if (npre == D - tp) ph = M_ARMED;
        end
        M_ARMED: begin
          acnt++;
          if (trigger) begin ta = (w0 + we_e) % D; ph = M_POST; end
        end
        M_POST: begin
          npost += we_e;
          if (scd_e) begin sa = wa; ph = M_DONE; end
        end
        default: if (capture_done_clr) ph = M_IDLE;
      endcase
      trig_q = scd_e ? 1'b0 : (trig_q | trig_set);
    end
    #1;
    trigger = trig_q;
  endtask
  task automatic run_capture(input int t, input int d, input int td, input bit post_start, input bit clr_start);
    int n;
    trig_pos = AW'(t); decimator = 4'(d); tdel = td;
    capture_start = 1'b1;
    cycle();
    capture_start = 1'b0;
    trig_pos = AW'($urandom); decimator = 4'($urandom);
    n = 0;
    while (ph != M_DONE && n < 3000) begin
      capture_start = post_start && ph == M_POST;
      cycle();
      n++;
    end
    capture_start = 1'b0;
    chk("done_within_budget", n < 3000, 1);
    repeat ($urandom_range(0, 3)) cycle();
    capture_done_clr = 1'b1; capture_start = clr_start;
    cycle();
    capture_done_clr = 1'b0; capture_start = 1'b0;
    repeat (3) cycle();
  endtask
  initial begin
    int n;
    rst = 1'b1; capture_start = 1'b0; capture_done_clr = 1'b0; trigger = 1'b0;
    trig_pos = '0; decimator = '0;
    @(posedge clk); #1;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    run_capture(4, 0, 1, 1'b0, 1'b0);
    chk("basic_trig_addr", trig_addr, 15);
    chk("basic_start_addr", start_addr, 3);
    run_capture(0, 0, 3, 1'b0, 1'b0);
    run_capture(5, 2, 2, 1'b0, 1'b0);
    trig_q = 1'b1; trigger = 1'b1;
    repeat (2) cycle();
    run_capture(3, 1, 99, 1'b1, 1'b1);
    trig_pos = 6; decimator = 1; tdel = 0;
    capture_start = 1'b1;
    cycle();
    capture_start = 1'b0;
    n = 0;
    while (!(ph == M_POST && npost == 2) && n < 1000) begin cycle(); n++; end
    chk("reach_post_budget", n < 1000, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_scd", set_capture_done, 0);
    chk("rst_armed", armed, 0);
    chk("rst_waddr", waddr, 0);
    repeat (2) cycle();
    run_capture(2, 0, 0, 1'b0, 1'b0);
    repeat (8) run_capture($urandom_range(0, 15), $urandom_range(0, 2), $urandom_range(0, 5),
                           1'($urandom), 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
